uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Asynchronous serial receiver, 8N1 framing (optional even parity), LSB first.
//  Samples the rx line at mid-bit using a baud counter, then presents each byte
//  on a valid/ready interface. Frame, parity and overrun errors are flagged.
//  Sits between the FPGA pin and byte-level consumers; pairs with the uart_tx link.
// PARAMETERS
//  CLOCK_RATE_HZ    100_000_000                      clk frequency
//  BAUD_RATE_HZ     115_200                          line rate
//  CLOCKS_PER_BAUD  CLOCK_RATE_HZ/BAUD_RATE_HZ       clocks per bit; must be >= 4
// PORTS
//  clk         in   1  clock; all logic on posedge
//  rst         in   1  reset; synchronous, active-high
//  rx          in   1  serial line, asynchronous, idle high
//  data        out  8  received byte; stable while valid=1
//  valid       out  1  data holds an unconsumed byte
//  ready       in   1  consumer accepts data when valid && ready
//  frame_err   out  1  1-cycle pulse: stop bit sampled 0
//  parity_err  out  1  1-cycle pulse: parity mismatch (tied 0 unless macro)
//  overrun     out  1  1-cycle pulse: byte completed while previous unconsumed
//  busy        out  1  state != IDLE
// BEHAVIOUR
//  - Reset: data=0, valid=0, frame_err=0, parity_err=0, overrun=0, busy=0.
//    State=IDLE, counters=0, synchroniser flops=1. Reset mid-frame aborts it.
//  - rx passes through a 2-flop synchroniser (rx_s); all decisions use rx_s.
//  - States: IDLE, START, DATA, [PARITY], STOP.
//  - IDLE: rx_s==0 -> START, baud_cnt = CLOCKS_PER_BAUD/2 - 1.
//  - baud_cnt counts down; bit sample ("tick") when baud_cnt==0. Each tick
//    reloads it with CLOCKS_PER_BAUD-1.
//  - START tick: rx_s==1 -> glitch, back to IDLE (no flags); else -> DATA, bit_cnt=0.
//  - DATA tick: shift rx_s into shreg[7] (right shift); bit_cnt+1; after 8th bit
//    -> PARITY if macro defined, else STOP.
//  - STOP tick: rx_s==1 -> commit byte; rx_s==0 -> frame_err=1 for one cycle,
//    no commit. Either way -> IDLE. A line held low (break) does not retrigger
//    until rx_s has been seen high for at least one cycle.
//  - Commit (cycle after STOP tick): if !valid or (valid && ready) this cycle,
//    data<=shreg, valid<=1. Else old data kept, new byte dropped, overrun=1.
//  - Handshake: valid falls the cycle after valid && ready unless a commit
//    coincides (then valid stays 1 with new data).
//  - Latency: valid rises 2 + CLOCKS_PER_BAUD/2 + 9*CLOCKS_PER_BAUD + 1 clocks
//    after the rx falling edge (+CLOCKS_PER_BAUD with parity).
//  - Back-to-back frames: a start edge is accepted in the first IDLE cycle after STOP.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: adds PARITY state after bit 8. Even parity expected
//   (XOR of 8 data bits and parity bit == 0). On mismatch, parity_err pulses 1
//   cycle with the commit; byte is still committed.
//  Undefined: 8N1 only, no PARITY state, parity_err held 0.
// TESTING  (bench: CLOCK_RATE_HZ=1_600_000, BAUD_RATE_HZ=100_000 -> 16 clk/bit)
//  1. Send 0xA5, ready=1 -> valid 1 cycle, data=0xA5, at edge+2+8+144+1 clk.
//  2. rx low for 5 clk then high -> no valid, no flags, busy back to 0 by mid-start.
//  3. 0x3C with stop bit 0 -> frame_err 1-cycle pulse, valid stays 0.
//  4. 0x11 then 0x22 back-to-back, ready=0 -> data=0x11 held, overrun pulse
//     on 2nd commit; ready=1 then clears valid next cycle.
//  5. Reset asserted mid-DATA of 0xFF, then send 0x5A -> only 0x5A received.
//  6. UART_RX_PARITY_EN: 0x07 with parity 1 -> data=0x07, parity_err=0;
//     parity 0 -> data=0x07, parity_err pulse.

Source files
------------

// File: rtl/uart_rx.sv
// Asynchronous 8N1 serial receiver with mid-bit sampling and a valid/ready byte output.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module uart_rx #(
  parameter int CLOCK_RATE_HZ   = 100_000_000,
  parameter int BAUD_RATE_HZ    = 115_200,
  parameter int CLOCKS_PER_BAUD = CLOCK_RATE_HZ / BAUD_RATE_HZ
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLOCKS_PER_BAUD);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLOCKS_PER_BAUD / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLOCKS_PER_BAUD - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_reg, state_next;
  logic            sync1_reg, rx_s_reg;
  logic [CW-1:0]   baud_cnt_reg;
  logic [2:0]      bit_cnt_reg;
  logic [7:0]      shreg_reg, data_reg;
  logic            valid_reg, frame_err_reg, overrun_reg;
  logic            armed_reg;
  logic            tick, start_det;
`ifdef UART_RX_PARITY_EN
  logic            par_bad_reg, parity_err_reg;
`endif

  assign tick = (baud_cnt_reg == '0);
  // armed_reg blocks a held-low (break) line from looking like a fresh start edge
  assign start_det = (state_reg == IDLE) && !rx_s_reg && armed_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (start_det) state_next = START;
      START:  if (tick) state_next = rx_s_reg ? IDLE : DATA;
      DATA:   if (tick && bit_cnt_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
        state_next = PARITY;
`else
        state_next = STOP;
`endif
      end
      PARITY: if (tick) state_next = STOP;
      STOP:   if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg      <= 1'b1;
      rx_s_reg       <= 1'b1;
      baud_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      shreg_reg      <= '0;
      data_reg       <= '0;
      valid_reg      <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
      armed_reg      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_reg    <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      sync1_reg     <= rx;
      rx_s_reg      <= sync1_reg;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_reg <= 1'b0;
`endif
      if (rx_s_reg) armed_reg <= 1'b1;
      if (valid_reg && ready) valid_reg <= 1'b0;

      if (state_reg == IDLE) begin
        if (start_det) baud_cnt_reg <= HALF_LOAD;
      end else begin
        baud_cnt_reg <= tick ? FULL_LOAD : baud_cnt_reg - CW'(1);
      end

      if (tick) begin
        case (state_reg)
          START: bit_cnt_reg <= '0;
          DATA: begin
            shreg_reg   <= {rx_s_reg, shreg_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
          end
`ifdef UART_RX_PARITY_EN
          PARITY: par_bad_reg <= ^{shreg_reg, rx_s_reg};
`endif
          STOP: begin
            if (rx_s_reg) begin
              // A consumer taking the old byte this cycle frees the slot for the new one
              if (!valid_reg || ready) begin
                data_reg  <= shreg_reg;
                valid_reg <= 1'b1;
              end else begin
                overrun_reg <= 1'b1;
              end
`ifdef UART_RX_PARITY_EN
              parity_err_reg <= par_bad_reg;
`endif
            end else begin
              frame_err_reg <= 1'b1;
              armed_reg     <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign data      = data_reg;
  assign valid     = valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
  assign busy      = (state_reg != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: transaction-level model of byte arrival plus literal pins.
// Runs the parity cases only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // falling edge to valid: 2 sync + half bit + remaining bits up to mid-stop + 1
  localparam int LAT = 2 + CPB / 2 + (NBITS - 1) * CPB + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, overrun, busy;

  always #5 clk = ~clk;

  uart_rx #(.CLOCK_RATE_HZ(1_600_000), .BAUD_RATE_HZ(100_000)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid), .ready(ready),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .busy(busy)
  );

  typedef struct {
    int       when;
    logic [7:0] b;
    bit       stop_ok;
    bit       par_bad;
  } ev_t;

  ev_t        evq[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_data = 8'h00;
  bit         m_valid = 0, m_fe = 0, m_ov = 0, m_pe = 0;
  bit         model_live = 0;
  int         fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, vrise_cnt = 0;
  bit         prev_valid = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a received frame lands LAT edges after its start bit begins.
  always @(posedge clk) begin : model
    ev_t ev;
    bit  take;
    bit  nvalid;
    cyc++;
    model_live = 1;
    m_fe = 0; m_ov = 0; m_pe = 0;
    if (rst) begin
      m_valid = 0;
      m_data  = 8'h00;
      evq.delete();
    end else begin
      take = 0;
      if (evq.size() > 0 && evq[0].when == cyc) begin
        ev = evq.pop_front();
        take = 1;
      end
      nvalid = m_valid && !ready;
      if (take) begin
        if (ev.stop_ok) begin
          if (!m_valid || ready) begin
            m_data = ev.b;
            nvalid = 1;
          end else begin
            m_ov = 1;
          end
          m_pe = ev.par_bad;
        end else begin
          m_fe = 1;
        end
      end
      m_valid = nvalid;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("valid", {31'b0, valid}, {31'b0, m_valid});
      if (m_valid) check("data", {24'b0, data}, {24'b0, m_data});
      check("frame_err", {31'b0, frame_err}, {31'b0, m_fe});
      check("overrun", {31'b0, overrun}, {31'b0, m_ov});
      check("parity_err", {31'b0, parity_err}, {31'b0, m_pe});
      if (frame_err === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
      if (parity_err === 1'b1) pe_cnt++;
      if (valid === 1'b1 && !prev_valid) vrise_cnt++;
      prev_valid = (valid === 1'b1);
    end
  end

  task automatic goto(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_counts();
    fe_cnt = 0; ov_cnt = 0; pe_cnt = 0; vrise_cnt = 0;
  endtask

  // Caller is at posedge+1; the start bit begins immediately.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit par_bit);
    logic [NBITS-1:0] bits;
    ev_t ev;
    bits[0]   = 1'b0;
    bits[8:1] = b;
`ifdef UART_RX_PARITY_EN
    bits[9]   = par_bit;
    ev.par_bad = (^b) ^ par_bit;
`else
    ev.par_bad = 1'b0;
    if (par_bit) bits[0] = 1'b0;
`endif
    bits[NBITS-1] = stop_bit;
    ev.when    = cyc + LAT;
    ev.b       = b;
    ev.stop_ok = stop_bit;
    evq.push_back(ev);
    $display("frame data=0x%02h stop=%0d par=%0d start_cycle=%0d", b, stop_bit, par_bit, cyc);
    for (int i = 0; i < NBITS; i++) begin
      rx = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL timeout actual=%0d required=<100000 cycles", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] vec [5];
    int t0;
    vec[0] = 8'h00; vec[1] = 8'hFF; vec[2] = 8'h80; vec[3] = 8'h01; vec[4] = 8'h96;

    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", {31'b0, valid}, 32'd0);
    check("reset_data", {24'b0, data}, 32'h00);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_flags", {29'b0, frame_err, parity_err, overrun}, 32'd0);
    rst = 1'b0;
    goto(cyc + 4);

    // 1: single byte, latency and busy window pinned by hand
    clear_counts();
    ready = 1'b1;
    t0 = cyc;
    fork
      send_frame(8'hA5, 1'b1, ^8'hA5);
      begin
        goto(t0 + 2);
        check("t1_busy_before", {31'b0, busy}, 32'd0);
        goto(t0 + 3);
        check("t1_busy_start", {31'b0, busy}, 32'd1);
        goto(t0 + LAT - 1);
        check("t1_valid_early", {31'b0, valid}, 32'd0);
        goto(t0 + LAT);
        check("t1_valid", {31'b0, valid}, 32'd1);
        check("t1_data", {24'b0, data}, 32'hA5);
        check("t1_busy_after", {31'b0, busy}, 32'd0);
        goto(t0 + LAT + 1);
        check("t1_valid_clear", {31'b0, valid}, 32'd0);
      end
    join
    goto(cyc + 4);

    // 2: short glitch on the line
    clear_counts();
    t0 = cyc;
    rx = 1'b0;
    goto(t0 + 5);
    rx = 1'b1;
    goto(t0 + 10);
    check("t2_busy_mid", {31'b0, busy}, 32'd1);
    goto(t0 + 11);
    check("t2_busy_idle", {31'b0, busy}, 32'd0);
    goto(t0 + 200);
    check("t2_no_valid", vrise_cnt, 32'd0);
    check("t2_no_fe", fe_cnt, 32'd0);

    // 3: stop bit sampled low
    clear_counts();
    send_frame(8'h3C, 1'b0, ^8'h3C);
    goto(cyc + 20);
    check("t3_fe_pulses", fe_cnt, 32'd1);
    check("t3_no_valid", vrise_cnt, 32'd0);

    // 4: back-to-back with consumer stalled
    clear_counts();
    ready = 1'b0;
    send_frame(8'h11, 1'b1, ^8'h11);
    send_frame(8'h22, 1'b1, ^8'h22);
    goto(cyc + 5);
    check("t4_data_held", {24'b0, data}, 32'h11);
    check("t4_valid_held", {31'b0, valid}, 32'd1);
    check("t4_overruns", ov_cnt, 32'd1);
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    check("t4_valid_drop", {31'b0, valid}, 32'd0);
    goto(cyc + 4);

    // 5: reset in the middle of a 0xFF frame, then a clean 0x5A
    clear_counts();
    rx = 1'b0;
    goto(cyc + CPB);
    rx = 1'b1;
    goto(cyc + 2 * CPB);
    check("t5_busy_mid", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_busy_rst", {31'b0, busy}, 32'd0);
    check("t5_data_rst", {24'b0, data}, 32'h00);
    rst = 1'b0;
    goto(cyc + 200);
    ready = 1'b1;
    send_frame(8'h5A, 1'b1, ^8'h5A);
    goto(cyc + 5);
    check("t5_one_byte", vrise_cnt, 32'd1);
    check("t5_data", {24'b0, data}, 32'h5A);

    // Stream of patterns with the consumer always ready
    clear_counts();
    for (int i = 0; i < 5; i++) send_frame(vec[i], 1'b1, ^vec[i]);
    goto(cyc + 5);
    check("stream_bytes", vrise_cnt, 32'd5);
    check("stream_last", {24'b0, data}, 32'h96);

`ifdef UART_RX_PARITY_EN
    // 6: good parity then bad parity on 0x07
    clear_counts();
    send_frame(8'h07, 1'b1, 1'b1);
    goto(cyc + 5);
    check("t6_good_pe", pe_cnt, 32'd0);
    check("t6_good_data", {24'b0, data}, 32'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    goto(cyc + 5);
    check("t6_bad_pe", pe_cnt, 32'd1);
    check("t6_bad_bytes", vrise_cnt, 32'd2);
`endif

    goto(cyc + 20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
